// File: rtl/real_mem_to_reg_if.sv
// Load-path bus between the control unit and the memory-to-register datapath slice.
// The master drives addresses, enables and write data. The slave returns the selected register.
interface real_mem_to_reg_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] AData;
    logic              MemWrite;
    logic [DATA_W-1:0] MemData;
    logic              IRWrite;
    logic [DATA_W-1:0] IRData;
    logic              RegWrite;
    logic [DATA_W-1:0] AccOut;

    modport master (
        output AData,
        output MemWrite,
        output MemData,
        output IRWrite,
        output IRData,
        output RegWrite,
        input  AccOut
    );

    modport slave (
        input  AData,
        input  MemWrite,
        input  MemData,
        input  IRWrite,
        input  IRData,
        input  RegWrite,
        output AccOut
    );
endinterface

// File: rtl/real_mem_to_reg.sv
// Memory-to-register load slice: IR, 256x16 data memory, 16x16 register file. AccOut is the register at IR[3:0].
// Latency: every update takes effect on one clock edge, and AccOut follows state combinationally. There is no backpressure.
module real_mem_to_reg #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 8,
    parameter int REG_AW = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    real_mem_to_reg_if.slave bus
);
    localparam int MEM_DEPTH = 2 ** MEM_AW;
    localparam int REG_DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mem  [MEM_DEPTH];
    logic [DATA_W-1:0] regs [REG_DEPTH];

    logic [MEM_AW-1:0] mem_addr;
    logic [REG_AW-1:0] reg_idx;
    logic [DATA_W-1:0] mem_out;

    // High address bits alias, and IR bits above the register index are stored but not used here.
    logic unused_bits;
    assign unused_bits = ^{bus.AData[DATA_W-1:MEM_AW], ir[DATA_W-1:REG_AW]};

    assign mem_addr   = bus.AData[MEM_AW-1:0];
    assign reg_idx    = ir[REG_AW-1:0];
    assign mem_out    = mem[mem_addr];
    assign bus.AccOut = regs[reg_idx];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ir <= '0;
        end else if (bus.IRWrite) begin
            ir <= bus.IRData;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.MemWrite) begin
            mem[mem_addr] <= bus.MemData;
        end
    end

    // Non-blocking updates make same-edge loads see the pre-edge IR index and memory word.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.RegWrite) begin
            regs[reg_idx] <= mem_out;
        end
    end
endmodule

// File: tb/tb_real_mem_to_reg.sv
// Bench for real_mem_to_reg. It runs directed and randomized load-path traffic against an array-based reference model.
module tb_real_mem_to_reg;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    real_mem_to_reg_if #(.DATA_W(16)) bus ();

    real_mem_to_reg dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    logic [15:0] m_ir;
    logic [15:0] m_mem  [256];
    logic [15:0] m_regs [16];
    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        m_ir = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
    endtask

    function automatic logic [15:0] model_acc();
        return m_regs[m_ir[3:0]];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_en();
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegWrite = 1'b0;
    endtask

    // Drive one cycle's inputs, apply the architectural rules to the model at the edge, and compare AccOut afterwards.
    task automatic cyc(input logic [15:0] a, input logic mw, input logic [15:0] md,
                       input logic irw, input logic [15:0] ird, input logic rw,
                       input string tag);
        logic [15:0] old_word;
        logic [3:0]  old_idx;
        @(negedge CLK);
        bus.AData = a; bus.MemWrite = mw; bus.MemData = md;
        bus.IRWrite = irw; bus.IRData = ird; bus.RegWrite = rw;
        @(posedge CLK);
        old_word = m_mem[a[7:0]];
        old_idx  = m_ir[3:0];
        if (rw)  m_regs[old_idx] = old_word;
        if (mw)  m_mem[a[7:0]]   = md;
        if (irw) m_ir            = ird;
        #1;
        check(tag, bus.AccOut, model_acc());
    endtask

    initial begin
        model_reset();
        bus.AData = '0; bus.MemData = '0; bus.IRData = '0;
        clear_en();

        // Reset is held with random inputs and toggling enables.
        for (int i = 0; i < 20; i++) begin
            bus.AData    = 16'($urandom);
            bus.MemData  = 16'($urandom);
            bus.IRData   = 16'($urandom);
            bus.MemWrite = 1'($urandom);
            bus.IRWrite  = 1'($urandom);
            bus.RegWrite = 1'($urandom);
            #5;
            check("reset_hold", bus.AccOut, 16'h0000);
        end
        @(negedge CLK);
        clear_en();
        RESET_N = 1'b1;
        #1;
        check("reset_release", bus.AccOut, 16'h0000);

        for (int r = 0; r < 16; r++)
            cyc(16'h0000, 1'b0, 16'h0, 1'b1, 16'(r), 1'b0, "reg_zero");
        cyc(16'h0000, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, "ir_zero");
        for (int a = 0; a < 256; a++)
            cyc(16'(a), 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, "mem_zero");

        // The register index comes from the old IR.
        cyc(16'h0001, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b1, "ir_load");
        check("ir_load_const", bus.AccOut, 16'h0000);

        cyc(16'h0001, 1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b0, "store");
        cyc(16'h0001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, "load");
        check("store_load_const", bus.AccOut, 16'hBEEF);

        // A load on the same edge as a write returns the old memory word.
        cyc(16'h0007, 1'b1, 16'h1111, 1'b0, 16'h0, 1'b0, "rbw_pre");
        cyc(16'h0000, 1'b0, 16'h0, 1'b1, 16'h0002, 1'b0, "rbw_ir");
        cyc(16'h0007, 1'b1, 16'h2222, 1'b0, 16'h0, 1'b1, "rbw");
        check("rbw_const", bus.AccOut, 16'h1111);
        cyc(16'h0007, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, "rbw_after");
        check("rbw_after_const", bus.AccOut, 16'h2222);

        cyc(16'hFF03, 1'b1, 16'h00A5, 1'b1, 16'h000F, 1'b0, "alias_store");
        cyc(16'hFF03, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, "alias_load");
        check("alias_const", bus.AccOut, 16'h00A5);
        cyc(16'h0003, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b0, "idx_switch");
        check("idx_switch_const", bus.AccOut, 16'hBEEF);

        // With all three enables on one edge, the old IR index and the old memory word are used.
        cyc(16'h0007, 1'b1, 16'h3333, 1'b1, 16'h0005, 1'b1, "triple");
        cyc(16'h0000, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b0, "triple_view");
        check("triple_const", bus.AccOut, 16'h2222);
        cyc(16'h0107, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, "triple_mem");
        check("triple_mem_const", bus.AccOut, 16'h3333);

        for (int i = 0; i < 4; i++)
            cyc(16'(16'h0010 + i), 1'b1, 16'(16'h5000 + i), 1'b0, 16'h0, 1'b1, "held");

        for (int i = 0; i < 500; i++)
            cyc(16'($urandom_range(0, 15)) | (16'($urandom) & 16'hFF00),
                1'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                16'($urandom), 1'($urandom), "random");

        cyc(16'h0001, 1'b1, 16'hBEEF, 1'b1, 16'h0001, 1'b0, "pre_arst_store");
        cyc(16'h0001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, "pre_arst_load");
        check("pre_arst_const", bus.AccOut, 16'hBEEF);
        @(posedge CLK);
        #2;
        clear_en();
        RESET_N = 1'b0;
        model_reset();
        #1;
        check("arst_immediate", bus.AccOut, 16'h0000);
        #1;
        RESET_N = 1'b1;
        cyc(16'h0001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, "arst_mem1");
        check("arst_mem1_const", bus.AccOut, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/real_mem_to_reg.md
Name: real_mem_to_reg

Overview:
- Datapath slice implementing the "memory-to-register" load path of the 16-bit processor.
- Holds an instruction register (IR), a 256x16 data memory and a 16x16 register file.
- A memory word addressed by AData is copied into the register selected by IR[3:0]; that register is presented on AccOut.
- Sits between the control unit (write enables) and the accumulator/ALU input of the datapath.

Parameters:
- DATA_W, 16, datapath word width.
- MEM_AW, 8, data-memory address width (2^MEM_AW words).
- REG_AW, 4, register-file index width (2^REG_AW registers), taken from IR[REG_AW-1:0].

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- AData  input  16  memory address source; only AData[MEM_AW-1:0] is used, upper bits are ignored.
- MemWrite  input  1  data-memory write enable.
- MemData  input  16  data-memory write data.
- IRWrite  input  1  IR load enable.
- IRData  input  16  IR load value.
- RegWrite  input  1  register-file write enable.
- AccOut  output  16  contents of register file entry IR[3:0].

Behaviour:
- Reset (RESET_N=0, asynchronous, no clock needed):
  - IR=0; all 256 memory words=0; all 16 registers=0; therefore AccOut=0.
  - Reset dominates every enable while asserted.
  - Deassertion is sampled normally; the first update occurs at the next rising edge with RESET_N=1.
- IR: on a rising edge with IRWrite=1, IR<=IRData; otherwise IR holds.
- Memory read:
  - Combinational, asynchronous: MemOut = mem[AData[7:0]].
  - MemOut is internal only.
- Memory write: on a rising edge with MemWrite=1, mem[AData[7:0]]<=MemData.
- Register write: on a rising edge with RegWrite=1, reg[IR[3:0]]<=MemOut.
- AccOut:
  - Combinational, AccOut = reg[IR[3:0]].
  - Updates within the same cycle when IR or the selected register changes; zero cycles of latency from the state change.
- Simultaneous events on one edge (all use pre-edge values):
  - IRWrite+RegWrite: the register index is the OLD IR[3:0]; the new IR takes effect on AccOut after the edge.
  - MemWrite+RegWrite to the same address: the register receives the OLD memory word (read-before-write); the new word is visible from the next cycle.
  - All three asserted together: the same rules combine.
- No register is hardwired; register 0 is writable.
- Address wrap: AData values >=256 alias to AData[7:0] (e.g. 16'h0105 addresses word 5).
- IR[15:4] is stored but unused by this block.
- Reset mid-operation: all state clears immediately, regardless of the clock.
- No handshake; each enable acts for exactly one edge per cycle asserted.
- Enables held high across multiple edges repeat the operation every edge.

Test Plan:
- Reset: hold RESET_N=0 for 100 ns with random inputs and toggling enables -> AccOut=0; after release IR, memory and registers all read 0.
- Load IR: IRData=16'h0001, IRWrite=1, RegWrite=1, AData=1, one edge:
  - reg[0]<=mem[1]=0 (old IR index 0) and IR<=1.
  - AccOut=reg[1]=0.
- Store then load:
  - MemWrite=1, AData=1, MemData=16'hBEEF, one edge.
  - Then RegWrite=1 with IR=1 -> AccOut=16'hBEEF after the edge.
- Read-before-write: mem[7]=16'h1111, IR=2; on the same edge MemWrite=1 (MemData=16'h2222, AData=7) and RegWrite=1:
  - AccOut=16'h1111 after the edge.
  - mem[7]=16'h2222 afterwards.
- Address aliasing and index select:
  - Write 16'h00A5 via AData=16'hFF03; load into reg[15] (IR=16'h000F) -> AccOut=16'h00A5.
  - Then IRWrite with IRData=16'h0001 -> AccOut switches to reg[1].
- Asynchronous reset mid-cycle: with AccOut=16'hBEEF, pulse RESET_N low between clock edges -> AccOut=0 immediately and mem[1]=0.
